// File: rtl/fixed_utils.sv
// rtl/fixed_utils.sv - Q16.16 constants and scheduler FSM encoding shared by the fixed-point ALU
package fixed_utils;

    localparam int          FRAC_BITS = 16;
    localparam logic [31:0] Q_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN     = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RSP  = 2'd2
    } state_t;

endpackage

// File: rtl/fixed_multiplier.sv
// rtl/fixed_multiplier.sv - combinational signed Q16.16 multiplier with truncation and overflow detect
module fixed_multiplier
    import fixed_utils::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow
);

    logic signed [63:0] product;
    logic signed [47:0] scaled;

    assign product = 64'($signed(a)) * 64'($signed(b));

    // Arithmetic shift drops the fraction bits (truncation toward minus infinity).
    assign scaled   = 48'(product >>> FRAC_BITS);
    assign result   = scaled[31:0];
    assign overflow = (scaled[47:32] != {16{scaled[31]}});

endmodule

// File: rtl/fixed_mul_scheduler.sv
// rtl/fixed_mul_scheduler.sv - round-robin sharing of one Q16.16 multiplier; FIXED_MUL_SAT_EN enables saturation
module fixed_mul_scheduler
    import fixed_utils::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_overflow,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    state_t          state;
    state_t          next_state;
    logic [ID_W-1:0] rr_ptr;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [ID_W-1:0] op_id;
    logic [31:0]     mul_result;
    logic            mul_overflow;
    logic [31:0]     mul_sel;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    next_state          = MUL;
                end
            end
            MUL: begin
                next_state = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == RSP);
    assign busy      = (state != IDLE);

    fixed_multiplier u_mul (
        .a        (op_a),
        .b        (op_b),
        .result   (mul_result),
        .overflow (mul_overflow)
    );

`ifdef FIXED_MUL_SAT_EN
    logic prod_neg;

    // A zero operand makes the true product zero, hence non-negative.
    assign prod_neg = (op_a[31] ^ op_b[31]) && (op_a != '0) && (op_b != '0);
    assign mul_sel  = mul_overflow ? (prod_neg ? Q_MIN : Q_MAX) : mul_result;
`else
    assign mul_sel  = mul_result;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_id        <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_id       <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                op_a   <= req_a[32*int'(grant_id) +: 32];
                op_b   <= req_b[32*int'(grant_id) +: 32];
                op_id  <= grant_id;
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state == MUL) begin
                rsp_result   <= mul_sel;
                rsp_overflow <= mul_overflow;
                rsp_id       <= op_id;
            end
        end
    end

endmodule

// File: doc/fixed_mul_scheduler.md
# fixed_mul_scheduler

Round-robin scheduler that shares one combinational Q16.16 multiplier among up to four requesters in the fixed-point ALU. It arbitrates valid/ready requests and latches the winning operands. It registers the product and overflow flag, then holds the response until the consumer accepts it, tagged with the requester index.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal values are 2..4.
- `ID_W`, default 2: width of `rsp_id`; must be at least clog2(NUM_REQ).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: one-hot grant; the request is accepted when `req_valid[i] && req_ready[i]`.
- `req_a` in NUM_REQ*32: packed Q16.16 operand A; requester i is at bits [32i+31:32i].
- `req_b` in NUM_REQ*32: packed Q16.16 operand B.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 32: Q16.16 product.
- `rsp_overflow` out 1: product did not fit in Q16.16.
- `rsp_id` out ID_W: index of the requester that owns the response.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, MUL, RSP.
- IDLE:
  - If any `req_valid` is high, grant the first valid requester searching from `rr_ptr` upward, with wrap-around.
  - `req_ready` is combinational and asserted only in IDLE, and only for the winner.
  - On that edge: latch a, b and the id into operand registers, set `rr_ptr` to winner+1 mod NUM_REQ, and go to MUL.
- MUL: register the multiplier's result and overflow outputs into the response registers, then go to RSP.
- RSP:
  - `rsp_valid` is high; `rsp_result`, `rsp_overflow` and `rsp_id` stay stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - No grant is issued while in RSP or MUL.
- Arithmetic:
  - The 64-bit signed product's bits [47:16] form `rsp_result`.
  - Overflow is set when product[63:48] is not all equal to product[47].
  - Fractional bits below bit 16 are truncated, with no rounding.
- Boundary conditions:
  - Requester deasserts `req_valid` before it is granted: legal, and it is simply skipped.
  - All `req_valid` low in IDLE: remain in IDLE; `rr_ptr` unchanged.
  - Single requester asserting continuously: it is served every transaction.
  - `rsp_ready` already high when RSP is entered: the response completes in that cycle.
- Reset, asserted at any time:
  - State → IDLE, `rr_ptr` → 0.
  - Operand and response registers → 0.
  - Any in-flight operation is discarded and no response is emitted.

## Timing
- Output reset values: `req_ready` 0, `rsp_valid` 0, `rsp_result` 0x00000000, `rsp_overflow` 0, `rsp_id` 0, `busy` 0.
- Latency:
  - Handshake at edge T.
  - MUL during cycle T+1.
  - `rsp_valid` high from the cycle after edge T+1.
  - Response visible 2 cycles after acceptance.
- Throughput: 1 operation per 3 cycles with `rsp_ready` held high; each stalled cycle adds 1.
- `req_ready` never asserts in the cycle after a handshake, because the FSM is in MUL.

## Configuration
- `FIXED_MUL_SAT_EN` defined:
  - On overflow, `rsp_result` saturates to 0x7FFFFFFF if the product is positive, else 0x80000000.
  - The product sign is a[31]^b[31], with zero operands treated as positive.
  - `rsp_overflow` is still reported.
- `FIXED_MUL_SAT_EN` undefined: `rsp_result` is the wrapped bits [47:16].

## Structure
- Shared package `fixed_utils` holds:
  - Q16.16 constants: FRAC_BITS=16, Q_MAX=0x7FFFFFFF, Q_MIN=0x80000000.
  - FSM state encoding constants: IDLE=2'd0, MUL=2'd1, RSP=2'd2.
- Sub-module: instantiate the existing `fixed_multiplier` once as the shared datapath, fed from the operand registers.
- Saturation muxing lives in this block, after the multiplier.

## Test plan
- Basic multiply: req0 with a=0x00018000, b=0x00020000 → after 2 cycles, `rsp_result`=0x00030000, `rsp_overflow`=0, `rsp_id`=0.
- Signed multiply: req1 with a=0xFFFF0000, b=0x00008000 → `rsp_result`=0xFFFF8000, overflow 0, `rsp_id`=1.
- Overflow: a=b=0x01000000 → overflow 1.
  - Without `FIXED_MUL_SAT_EN`: result 0x00000000.
  - With `FIXED_MUL_SAT_EN`: result 0x7FFFFFFF.
- Round-robin: req0 and req1 held valid for 4 transactions, `rsp_ready`=1 → grant order 0,1,0,1; `rsp_id` sequence 0,1,0,1.
- Backpressure: `rsp_ready` held low for 5 cycles in RSP → result, id and overflow stable, `req_ready` all 0, `busy` 1; accepted on the first high cycle, then back in IDLE.
- Reset: assert `rst` during MUL → all outputs at reset values immediately (asynchronous); after release, the next request from req1 with req0 idle is granted to req1, and `rr_ptr` restarts at 0.
